// File: rtl/operand_read_fwd.sv
// Operand-read stage: register file, EX/MEM/WB forwarding, load-use stall and
// an output pipeline register with valid/ready handshake and branch flush.
module operand_read_fwd #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = 3,
    parameter int IMM_W  = 6,
    parameter int FUNC_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          rs1_a,
    input  logic [AW-1:0]          rs2_a,
    input  logic [AW-1:0]          rd_a,
    input  logic                   rd_we,
    input  logic [FUNC_W-1:0]      func,
    input  logic [IMM_W-1:0]       imm,
    input  logic                   use_imm,
    input  logic [2:0]             flags_in,
    input  logic [DATA_W-1:0]      pc_in,
    input  logic                   flush,
    input  logic                   ex_we,
    input  logic [AW-1:0]          ex_a,
    input  logic [DATA_W-1:0]      ex_data,
    input  logic                   ex_is_load,
    input  logic                   mem_we,
    input  logic [AW-1:0]          mem_a,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_a,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_d1,
    output logic [DATA_W-1:0]      out_d2,
    output logic [FUNC_W-1:0]      out_func,
    output logic [AW-1:0]          out_rd_a,
    output logic                   out_rd_we,
    output logic [2:0]             out_flags,
    output logic [DATA_W-1:0]      out_pc,
    output logic [NREG*DATA_W-1:0] dbg_regs
);

    logic [DATA_W-1:0] r_rf [NREG];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_d1;
    logic [DATA_W-1:0] r_out_d2;
    logic [FUNC_W-1:0] r_out_func;
    logic [AW-1:0]     r_out_rd_a;
    logic              r_out_rd_we;
    logic [2:0]        r_out_flags;
    logic [DATA_W-1:0] r_out_pc;

    logic [DATA_W-1:0] w_rf_s1;
    logic [DATA_W-1:0] w_rf_s2;
    logic [DATA_W-1:0] w_d1;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_d2;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_hazard;
    logic              w_advance;
    logic              w_load;

    // Fixed-priority bypass; a load still in EX has no data yet and is skipped.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [AW-1:0]     src,
        input logic [DATA_W-1:0] rfVal,
        input logic              exWe,
        input logic [AW-1:0]     exA,
        input logic [DATA_W-1:0] exData,
        input logic              exIsLoad,
        input logic              memWe,
        input logic [AW-1:0]     memA,
        input logic [DATA_W-1:0] memData,
        input logic              wbWe,
        input logic [AW-1:0]     wbA,
        input logic [DATA_W-1:0] wbData
    );
        logic [DATA_W-1:0] val;
        val = rfVal;
        if (exWe && exA == src && !exIsLoad) begin
            val = exData;
        end else if (memWe && memA == src) begin
            val = memData;
        end else if (wbWe && wbA == src) begin
            val = wbData;
        end
        return val;
    endfunction

    always_comb begin
        w_rf_s1   = r_rf[rs1_a];
        w_rf_s2   = r_rf[rs2_a];
        w_imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        w_d1      = resolve(rs1_a, w_rf_s1, ex_we, ex_a, ex_data, ex_is_load,
                            mem_we, mem_a, mem_data, wb_we, wb_a, wb_data);
        w_rs2_val = resolve(rs2_a, w_rf_s2, ex_we, ex_a, ex_data, ex_is_load,
                            mem_we, mem_a, mem_data, wb_we, wb_a, wb_data);
        w_d2      = use_imm ? w_imm_ext : w_rs2_val;
    end

    assign w_hazard  = ex_we & ex_is_load & in_valid &
                       ((ex_a == rs1_a) | (!use_imm & (ex_a == rs2_a)));
    assign w_advance = out_ready | !r_out_valid;
    assign w_load    = w_advance & in_valid & !w_hazard;
    assign in_ready  = w_advance & !w_hazard & !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_rf[k] <= '0;
            end
        end else if (wb_we) begin
            r_rf[wb_a] <= wb_data;
        end
    end

    // Flush outranks everything, including a stalled output slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_d1    <= '0;
            r_out_d2    <= '0;
            r_out_func  <= '0;
            r_out_rd_a  <= '0;
            r_out_rd_we <= 1'b0;
            r_out_flags <= '0;
            r_out_pc    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_d1    <= w_d1;
            r_out_d2    <= w_d2;
            r_out_func  <= func;
            r_out_rd_a  <= rd_a;
            r_out_rd_we <= rd_we;
            r_out_flags <= flags_in;
            r_out_pc    <= pc_in;
        end else if (w_advance) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_d1    = r_out_d1;
    assign out_d2    = r_out_d2;
    assign out_func  = r_out_func;
    assign out_rd_a  = r_out_rd_a;
    assign out_rd_we = r_out_rd_we;
    assign out_flags = r_out_flags;
    assign out_pc    = r_out_pc;

    for (genvar k = 0; k < NREG; k++) begin : g_dbg
        assign dbg_regs[k*DATA_W +: DATA_W] = r_rf[k];
    end

endmodule
